// File: rtl/rsa_modexp_seq.sv
// Right-to-left square-and-multiply modular exponentiation, one exponent bit per clock.
// Define RSA_EARLY_EXIT_EN to stop as soon as the remaining exponent bits are zero.
module rsa_modexp_seq #(
   parameter int W     = 14,
   parameter int EXP_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [W-1:0]     cipher,
   input  logic [EXP_W-1:0] exp_d,
   input  logic [W-1:0]     mod_n,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [W-1:0]     result
);

   localparam int CW = $clog2(EXP_W + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     base_q, base_d;
   logic [W-1:0]     n_q, n_d;
   logic [W-1:0]     result_q, result_d;
   logic [EXP_W-1:0] e_q, e_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [2*W-1:0]   n_div, prod_acc, prod_base;
   logic [W-1:0]     cin_div, cin_red;
   logic [W-1:0]     acc_step, base_step;
   logic             accept, bad_n, last_step;

   // Divisors forced nonzero so idle-cycle arithmetic stays defined.
   always_comb begin
      n_div     = (n_q == '0) ? (2*W)'(1) : {{W{1'b0}}, n_q};
      cin_div   = (mod_n == '0) ? W'(1) : mod_n;
      prod_acc  = {{W{1'b0}}, acc_q} * {{W{1'b0}}, base_q};
      prod_base = {{W{1'b0}}, base_q} * {{W{1'b0}}, base_q};
      acc_step  = e_q[0] ? W'(prod_acc % n_div) : acc_q;
      base_step = W'(prod_base % n_div);
      cin_red   = cipher % cin_div;
   end

   assign bad_n  = (mod_n < W'(2));
   assign accept = start && (state_q != RUN);

`ifdef RSA_EARLY_EXIT_EN
   assign last_step = (cnt_q == CW'(EXP_W - 1)) || ((e_q >> 1) == '0);
`else
   assign last_step = (cnt_q == CW'(EXP_W - 1));
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      base_d   = base_q;
      n_d      = n_q;
      e_d      = e_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
      unique case (state_q)
         RUN: begin
            acc_d  = acc_step;
            base_d = base_step;
            e_d    = e_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            if (last_step) begin
               result_d = acc_step;
               state_d  = DONE;
            end
         end
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               if (bad_n) begin
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = DONE;
               end else begin
                  acc_d   = W'(1);
                  base_d  = cin_red;
                  n_d     = mod_n;
                  e_d     = exp_d;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = RUN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         base_q   <= '0;
         n_q      <= '0;
         e_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         base_q   <= base_d;
         n_q      <= n_d;
         e_q      <= e_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Scoreboard bench for rsa_modexp_seq: driver pushes expectations, monitor checks on done.
// Latency expectations follow RSA_EARLY_EXIT_EN when it is defined.
module tb_rsa_modexp_seq;

   localparam int W     = 14;
   localparam int EXP_W = 14;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [W-1:0]     cipher;
   logic [EXP_W-1:0] exp_d;
   logic [W-1:0]     mod_n;
   logic             busy, done, err;
   logic [W-1:0]     result;

   typedef struct {
      logic [W-1:0] res;
      bit           er;
      int           lat;
      int           scyc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_x;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   rsa_modexp_seq #(.W(W), .EXP_W(EXP_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cipher(cipher), .exp_d(exp_d), .mod_n(mod_n),
      .busy(busy), .done(done), .err(err), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] model(input longint c, input longint e, input longint n);
      longint r, b;
      r = 1;
      b = c % n;
      for (int i = EXP_W - 1; i >= 0; i--) begin
         r = (r * r) % n;
         if (((e >> i) & 1) == 1) r = (r * b) % n;
      end
      return W'(r);
   endfunction

   function automatic int exp_lat(input int e, input int n);
      int bl;
      bl = 0;
      if (n < 2) return 1;
`ifdef RSA_EARLY_EXIT_EN
      for (int i = 0; i < EXP_W; i++)
         if (((e >> i) & 1) == 1) bl = i + 1;
      return ((bl < 1) ? 1 : bl) + 1;
`else
      return EXP_W + 1 + bl;
`endif
   endfunction

   // Called at a negedge; start is sampled on the following posedge.
   task automatic issue(input int c, input int e, input int n, input bit push);
      exp_t x;
      cipher = W'(c);
      exp_d  = EXP_W'(e);
      mod_n  = W'(n);
      start  = 1'b1;
      if (push) begin
         x.scyc = cyc;
         x.res  = (n < 2) ? W'(0) : model(c, e, n);
         x.er   = (n < 2);
         x.lat  = exp_lat(e, n);
         sbq.push_back(x);
      end
      @(negedge clk);
      start  = 1'b0;
      cipher = W'($urandom);
      exp_d  = EXP_W'($urandom);
      mod_n  = W'($urandom);
   endtask

   task automatic wait_done(input string nm, input int exp_busy);
      int b;
      bit seen;
      b    = 0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) b++;
         @(negedge clk);
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s timeout: no done within 60 cycles", nm);
      end else begin
         tests++;
         if (b != exp_busy) begin
            fails++;
            $display("FAIL %s busy cycles: got %0d, want %0d", nm, b, exp_busy);
         end
      end
   endtask

   task automatic run(input string nm, input int c, input int e, input int n);
      issue(c, e, n, 1'b1);
      wait_done(nm, exp_lat(e, n) - 1);
   endtask

   task automatic chk(input string nm, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         tests++;
         if (busy) begin
            fails++;
            $display("FAIL done_busy_overlap: busy=%0b done=%0b", busy, done);
         end
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done at cycle %0d result=%0d", cyc, result);
         end else begin
            mon_x = sbq.pop_front();
            tests++;
            if (result !== mon_x.res) begin
               fails++;
               $display("FAIL result: got %0d, want %0d", result, mon_x.res);
            end
            tests++;
            if (err !== mon_x.er) begin
               fails++;
               $display("FAIL err: got %0b, want %0b", err, mon_x.er);
            end
            tests++;
            if (cyc - mon_x.scyc != mon_x.lat) begin
               fails++;
               $display("FAIL latency: got %0d, want %0d", cyc - mon_x.scyc, mon_x.lat);
            end
         end
      end
   end

   initial begin
      int c;
      rst_n  = 1'b0;
      start  = 1'b0;
      cipher = '0;
      exp_d  = '0;
      mod_n  = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_result", int'(result), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 2^3 mod 10573 = 8
      run("basic", 2, 3, 10573);
      @(negedge clk);

      // RSA round trip with e=89, d=233 over n=97*109
      for (int m = 0; m < 128; m++) begin
         c = int'(model(m, 89, 10573));
         run("encrypt", m, 89, 10573);
         sbq.push_back('{res: W'(m), er: 1'b0, lat: exp_lat(233, 10573), scyc: cyc});
         cipher = W'(c);
         exp_d  = EXP_W'(233);
         mod_n  = W'(10573);
         start  = 1'b1;
         @(negedge clk);
         start  = 1'b0;
         wait_done("decrypt", exp_lat(233, 10573) - 1);
      end
      @(negedge clk);

      // 10575 mod 10573 = 2; x^0 = 1; 0^5 = 0
      run("cipher_ge_n", 10575, 1, 10573);
      run("exp_zero", 1234, 0, 10573);
      run("cipher_zero", 0, 5, 10573);
      repeat (2) @(negedge clk);
      chk("result_held", int'(result), 0);

      run("mod_one", 5, 3, 1);
      repeat (3) @(negedge clk);
      chk("err_held", int'(err), 1);
      chk("err_result", int'(result), 0);
      run("mod_zero", 9, 9, 0);
      run("err_clear", 2, 3, 10573);
      @(negedge clk);

      // Start during RUN must be ignored
      issue(1234, 89, 10573, 1'b1);
      repeat (5) @(negedge clk);
      start  = 1'b1;
      cipher = W'(7);
      exp_d  = EXP_W'(1);
      mod_n  = W'(1);
      @(negedge clk);
      start  = 1'b0;
      wait_done("ignore_start", exp_lat(89, 10573) - 7);
      repeat (20) @(negedge clk);

      // Reset mid-RUN aborts without done
      issue(2, 3, 10573, 1'b0);
      repeat (4) @(negedge clk);
      chk("midrun_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_err", int'(err), 0);
      chk("abort_result", int'(result), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      run("after_abort", 3, 7, 10573);
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
